hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Central hazard unit for the parametrised CPU pipeline. Tracks in-flight destination registers
//  for every stage between Decode and Writeback in a shadow shift register.
//  Drives the Decode stall, the branch flush and per-operand forwarding selects into Execute.
//  Generalises the pipeline to any NUMREGISTERS and any DEPTH of post-decode stages.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  NUMREGISTERS  8   architectural registers tracked
//  DEPTH         3   post-decode stages, entry 1 = Execute ... entry DEPTH = Writeback (min 2)
//  REGW  $clog2(NUMREGISTERS)  register index width (derived, not overridden)
//  FWDW  $clog2(DEPTH+1)       forward-select width (derived)
//  CNTW          16  stall counter width
// PORTS
//  clk           in   1             pipeline clock
//  rst_n         in   1             async active-low reset
//  dec_valid     in   1             Decode holds a valid instruction
//  dec_src_a     in   REGW          source A index;  dec_use_a  in 1  source A is read
//  dec_src_b     in   REGW          source B index;  dec_use_b  in 1  source B is read
//  dec_dst       in   REGW          destination index
//  dec_wr_en     in   1             instruction writes dec_dst
//  dec_is_load   in   1             result available only after Memory stage
//  branch_taken  in   1             Execute resolved a taken branch this cycle
//  stall         out  1             hold Fetch/Decode, insert bubble into Execute
//  flush         out  1             kill Fetch and Decode contents this cycle
//  fwd_a_sel     out  FWDW          0 = regfile, k = result of entry k
//  fwd_b_sel     out  FWDW          as fwd_a_sel for operand B
//  busy_mask     out  NUMREGISTERS  bit r set while any in-flight entry will write r
//  stall_cnt     out  CNTW          stall cycles since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset: all entries invalid; stall=0, flush=0, fwd_*_sel=0, busy_mask=0, stall_cnt=0.
//  - State: DEPTH entries {valid, dst, wr_en, is_load}; all shift one stage every clock, entry DEPTH
//    retires. Entry 1 loads the Decode instr when dec_valid & !stall & !flush, else a bubble (valid=0).
//  - flush = branch_taken & entry1.valid (combinational). Entry 1 (the branch) is kept; Decode
//    instruction is dropped; Fetch/Decode pipe clears on flush.
//  - Match(k,src) = entry k valid & wr_en & dst==src & use & dec_valid. Youngest match (lowest k) wins.
//  - stall, fwd_* are combinational from state + Decode inputs; flush overrides stall (stall=0).
//  - Regfile is write-before-read: match only at entry DEPTH never stalls.
//  - busy_mask combinational OR over valid wr_en entries; entries leave the mask when they retire.
//  - stall_cnt increments on each cycle with stall=1; holds at 2^CNTW-1.
//  - Same dst in several entries: only the youngest is forwarded; older ones are ignored.
//  - Async reset mid-stream discards all entries immediately; no pending stall or flush survives reset.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined:
//   - stall only on load-use: youngest match is entry 1 with is_load.
//   - otherwise fwd_x_sel = k of the youngest match (0 when none).
//  HAZARD_FORWARDING_EN undefined:
//   - fwd_*_sel tied to 0.
//   - stall while any match exists in entries 1..DEPTH-1 (writeback covered by regfile bypass).
// TESTING  (DEPTH=3, NUMREGISTERS=8)
//  1 Reset held, inputs toggling -> all outputs 0, busy_mask=8'h00; release -> still 0 with dec_valid=0.
//  2 ADD r3 then ADD r4<-r3 next cycle, FWD_EN -> stall=0, fwd_a_sel=1; no FWD_EN -> stall 2 cycles then fwd=0.
//  3 LOAD r2 then use r2, FWD_EN -> stall=1 exactly 1 cycle, then fwd_a_sel=2; stall_cnt=1.
//  4 branch_taken with entry1 valid while dependent instr in Decode -> flush=1, stall=0, next entry1 invalid.
//  5 r5 written by entries 1 and 2, read as A and B -> fwd_a_sel=fwd_b_sel=1; busy_mask=8'h20.
//  6 Force 2^16+3 stall cycles -> stall_cnt=16'hFFFF; assert rst_n low mid-stall -> stall_cnt=0 at once.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard unit tracking in-flight destinations between Decode and Writeback.
//
// Drives the Decode stall, the taken-branch flush, per-operand forwarding selects and a busy-register
// mask. It also keeps a saturating count of stall cycles.
//
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding. With it, only a load-use
// dependency stalls. Without it, fwd_*_sel_o are tied to 0 and any dependency on a non-writeback
// entry stalls.
//
// Parameters:
//   NUMREGISTERS  architectural registers tracked
//   DEPTH         post-decode stages (entry 1 = Execute ... entry DEPTH = Writeback), at least 2
//   CNTW          stall counter width
//
// Ports:
//   clk             pipeline clock
//   rst_n           asynchronous active-low reset
//   dec_valid_i     Decode holds a valid instruction
//   dec_src_a_i     source A register index
//   dec_use_a_i     source A is read
//   dec_src_b_i     source B register index
//   dec_use_b_i     source B is read
//   dec_dst_i       destination register index
//   dec_wr_en_i     instruction writes dec_dst_i
//   dec_is_load_i   result is available only after the Memory stage
//   branch_taken_i  Execute resolved a taken branch this cycle
//   stall_o         hold Fetch/Decode and insert a bubble into Execute
//   flush_o         kill the Fetch and Decode contents this cycle
//   fwd_a_sel_o     operand A source: 0 = register file, k = result of entry k
//   fwd_b_sel_o     operand B source, encoded as for fwd_a_sel_o
//   busy_mask_o     bit r set while any in-flight entry will write r
//   stall_cnt_o     stall cycles since reset, saturating at all-ones
module hazard_scoreboard #(
    parameter int  NUMREGISTERS = 8,
    parameter int  DEPTH        = 3,
    parameter int  CNTW         = 16,
    localparam int REGW         = $clog2(NUMREGISTERS),
    localparam int FWDW         = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dec_valid_i,
    input  logic [REGW-1:0]         dec_src_a_i,
    input  logic                    dec_use_a_i,
    input  logic [REGW-1:0]         dec_src_b_i,
    input  logic                    dec_use_b_i,
    input  logic [REGW-1:0]         dec_dst_i,
    input  logic                    dec_wr_en_i,
    input  logic                    dec_is_load_i,
    input  logic                    branch_taken_i,
    output logic                    stall_o,
    output logic                    flush_o,
    output logic [FWDW-1:0]         fwd_a_sel_o,
    output logic [FWDW-1:0]         fwd_b_sel_o,
    output logic [NUMREGISTERS-1:0] busy_mask_o,
    output logic [CNTW-1:0]         stall_cnt_o
);
    logic [DEPTH:1]  v_q, v_d, wr_q, wr_d, ld_q, ld_d;
    logic [REGW-1:0] dst_q [1:DEPTH];
    logic [REGW-1:0] dst_d [1:DEPTH];
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [FWDW-1:0] sel_a, sel_b;
    logic            hz_a, hz_b, issue;
    logic            unused_ld;

    function automatic logic hit(input int k, input logic [REGW-1:0] src, input logic use_src);
        return dec_valid_i && use_src && v_q[k] && wr_q[k] && (dst_q[k] == src);
    endfunction

    // Scan from oldest to youngest so the lowest matching entry index wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit(k, dec_src_a_i, dec_use_a_i)) sel_a = FWDW'(k);
            if (hit(k, dec_src_b_i, dec_use_b_i)) sel_b = FWDW'(k);
        end
    end

    assign flush_o = branch_taken_i & v_q[1];

`ifdef HAZARD_FORWARDING_EN
    // A load in Execute has no result to forward yet.
    assign hz_a        = (sel_a == FWDW'(1)) & ld_q[1];
    assign hz_b        = (sel_b == FWDW'(1)) & ld_q[1];
    assign stall_o     = (hz_a | hz_b) & ~flush_o;
    assign fwd_a_sel_o = stall_o ? '0 : sel_a;
    assign fwd_b_sel_o = stall_o ? '0 : sel_b;
`else
    // Writeback-only matches are served by the write-before-read register file.
    assign hz_a        = (sel_a != '0) & (sel_a != FWDW'(DEPTH));
    assign hz_b        = (sel_b != '0) & (sel_b != FWDW'(DEPTH));
    assign stall_o     = (hz_a | hz_b) & ~flush_o;
    assign fwd_a_sel_o = '0;
    assign fwd_b_sel_o = '0;
`endif

    // Only entry 1 of the load flags affects hazards; the rest just travel with their entries.
    assign unused_ld = ^ld_q;

    // A stalled or flushed Decode slot enters Execute as a bubble.
    assign issue = dec_valid_i & ~stall_o & ~flush_o;

    always_comb begin
        v_d      = {v_q[DEPTH-1:1], issue};
        wr_d     = {wr_q[DEPTH-1:1], issue & dec_wr_en_i};
        ld_d     = {ld_q[DEPTH-1:1], issue & dec_is_load_i};
        dst_d[1] = dec_dst_i;
        for (int k = 2; k <= DEPTH; k++) dst_d[k] = dst_q[k-1];
        cnt_d    = (stall_o && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        busy_mask_o = '0;
        for (int k = 1; k <= DEPTH; k++)
            if (v_q[k] && wr_q[k]) busy_mask_o[dst_q[k]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 1; k <= DEPTH; k++) dst_q[k] <= '0;
        end else begin
            v_q   <= v_d;
            wr_q  <= wr_d;
            ld_q  <= ld_d;
            cnt_q <= cnt_d;
            dst_q <= dst_d;
        end
    end

    assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven checks of hazard_scoreboard with a queue of expected results.
module tb_hazard_scoreboard;
`ifdef HAZARD_FORWARDING_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif
    logic        clk;
    logic        rst_n;
    logic        dec_valid, ua, ub, wr, ld, br;
    logic [2:0]  sa, sb, dst;
    logic        stall, flush, s_stall, s_flush;
    logic [1:0]  fa, fb, s_fa, s_fb;
    logic [7:0]  busy, s_busy, s_cnt;
    logic [15:0] cnt;

    typedef struct packed {
        logic       v;
        logic [2:0] sa;
        logic       ua;
        logic [2:0] sb;
        logic       ub;
        logic [2:0] dst;
        logic       wr;
        logic       ld;
        logic       br;
        logic       st;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] busy;
    } vec_t;

    typedef struct packed {
        logic        st;
        logic        fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [7:0]  busy;
        logic [15:0] cnt;
    } exp_t;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    int          n_chk;
    int          n_pass;
    logic [15:0] exp_cnt;

    hazard_scoreboard #(.NUMREGISTERS(8), .DEPTH(3), .CNTW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .dec_src_a_i(sa), .dec_use_a_i(ua), .dec_src_b_i(sb), .dec_use_b_i(ub),
        .dec_dst_i(dst), .dec_wr_en_i(wr), .dec_is_load_i(ld), .branch_taken_i(br),
        .stall_o(stall), .flush_o(flush), .fwd_a_sel_o(fa), .fwd_b_sel_o(fb),
        .busy_mask_o(busy), .stall_cnt_o(cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    hazard_scoreboard #(.NUMREGISTERS(8), .DEPTH(3), .CNTW(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .dec_valid_i(dec_valid),
        .dec_src_a_i(sa), .dec_use_a_i(ua), .dec_src_b_i(sb), .dec_use_b_i(ub),
        .dec_dst_i(dst), .dec_wr_en_i(wr), .dec_is_load_i(ld), .branch_taken_i(br),
        .stall_o(s_stall), .flush_o(s_flush), .fwd_a_sel_o(s_fa), .fwd_b_sel_o(s_fb),
        .busy_mask_o(s_busy), .stall_cnt_o(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fw(input int with_fwd, input int without_fwd);
        return F ? with_fwd : without_fwd;
    endfunction

    function automatic vec_t mk(input int iv, input int isa, input int iua, input int isb, input int iub,
                                input int idst, input int iwr, input int ild, input int ibr,
                                input int est, input int efl, input int efa, input int efb, input int ebusy);
        vec_t r;
        r.v = 1'(iv); r.sa = 3'(isa); r.ua = 1'(iua); r.sb = 3'(isb); r.ub = 1'(iub);
        r.dst = 3'(idst); r.wr = 1'(iwr); r.ld = 1'(ild); r.br = 1'(ibr);
        r.st = 1'(est); r.fl = 1'(efl); r.fa = 2'(efa); r.fb = 2'(efb); r.busy = 8'(ebusy);
        return r;
    endfunction

    function automatic vec_t idle(input int ebusy);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ebusy);
    endfunction

    // Stall pattern while the same self-dependent load is held in Decode from an empty pipe.
    function automatic bit pat(input int i);
        return F ? (i % 2 == 1) : (i % 3 != 0);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    task automatic drive(input vec_t t);
        dec_valid = t.v; sa = t.sa; ua = t.ua; sb = t.sb; ub = t.ub;
        dst = t.dst; wr = t.wr; ld = t.ld; br = t.br;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " stall"}, 16'(stall), 16'h0);
        chk({nm, " flush"}, 16'(flush), 16'h0);
        chk({nm, " fwd_a"}, 16'(fa), 16'h0);
        chk({nm, " fwd_b"}, 16'(fb), 16'h0);
        chk({nm, " busy"}, 16'(busy), 16'h0);
        chk({nm, " cnt"}, cnt, 16'h0);
        chk({nm, " sat_cnt"}, 16'(s_cnt), 16'h0);
    endtask

    task automatic step(input vec_t t, input string nm);
        exp_t e;
        drive(t);
        e.st = t.st; e.fl = t.fl; e.fa = t.fa; e.fb = t.fb; e.busy = t.busy; e.cnt = exp_cnt;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        chk({nm, " stall"}, 16'(stall), 16'(e.st));
        chk({nm, " flush"}, 16'(flush), 16'(e.fl));
        chk({nm, " fwd_a"}, 16'(fa), 16'(e.fa));
        chk({nm, " fwd_b"}, 16'(fb), 16'(e.fb));
        chk({nm, " busy"}, 16'(busy), 16'(e.busy));
        chk({nm, " cnt"}, cnt, e.cnt);
        chk({nm, " sat_cnt"}, 16'(s_cnt), 16'(e.cnt[7:0]));
        if (e.st) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        int j;
        n_chk = 0;
        n_pass = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        drive(idle(0));

        // ADD r3; then ADD r4 <- r3 held in Decode
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 'h00));
        tbl.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, fw(0, 1), 0, fw(1, 0), 0, 'h08));
        tbl.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, fw(0, 1), 0, fw(2, 0), 0, fw('h18, 'h08)));
        tbl.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, fw(3, 0), 0, fw('h18, 'h08)));
        tbl.push_back(idle('h10));
        tbl.push_back(idle('h10));
        tbl.push_back(idle('h10));
        tbl.push_back(idle('h00));
        // LOAD r2; then r5 <- r2
        tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 'h00));
        tbl.push_back(mk(1, 2, 1, 0, 0, 5, 1, 0, 0, 1, 0, 0, 0, 'h04));
        tbl.push_back(mk(1, 2, 1, 0, 0, 5, 1, 0, 0, fw(0, 1), 0, fw(2, 0), 0, 'h04));
        tbl.push_back(mk(1, 2, 1, 0, 0, 5, 1, 0, 0, 0, 0, fw(3, 0), 0, fw('h24, 'h04)));
        tbl.push_back(idle('h20));
        tbl.push_back(idle('h20));
        tbl.push_back(idle('h20));
        tbl.push_back(idle('h00));
        // branch writing r6 in Execute, dependent instr in Decode, branch taken
        tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 'h00));
        tbl.push_back(mk(1, 6, 1, 0, 0, 7, 1, 0, 1, 0, 1, fw(1, 0), 0, 'h40));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h40));
        tbl.push_back(idle('h40));
        tbl.push_back(idle('h00));
        // r5 written twice, then read on both operands; unused operands and invalid Decode never match
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 'h00));
        tbl.push_back(mk(1, 5, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 'h20));
        tbl.push_back(mk(1, 5, 1, 5, 1, 1, 1, 0, 0, fw(0, 1), 0, fw(1, 0), fw(1, 0), 'h20));
        tbl.push_back(mk(0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, fw('h22, 'h20)));
        tbl.push_back(idle(fw('h22, 'h20)));
        tbl.push_back(idle(fw('h02, 'h00)));
        tbl.push_back(idle('h00));

        // reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {dec_valid, ua, ub, wr, ld, br} = 6'($urandom);
            sa = 3'($urandom); sb = 3'($urandom); dst = 3'($urandom);
            #1;
            chk_zero($sformatf("rst%0d", i));
        end
        @(negedge clk);
        drive(idle(0));
        rst_n = 1'b1;
        #1;
        chk_zero("release");
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // self-dependent load held in Decode: stall pattern and counter saturation
        for (int i = 0; i < 800; i++) begin
            drive(mk(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
            #1;
            chk($sformatf("sat%0d stall", i), 16'(stall), 16'(pat(i)));
            if (pat(i)) exp_cnt++;
            @(negedge clk);
        end
        #1;
        chk("sat cnt16", cnt, exp_cnt);
        chk("sat cnt8", 16'(s_cnt), 16'h00ff);

        // asynchronous reset in the middle of a stall
        for (j = 800; !pat(j); j++) @(negedge clk);
        #1;
        chk("pre_rst stall", 16'(stall), 16'h1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_zero("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
